// File: rtl/game_move.sv
// game_move: move engine feeding game_retract.
// Latches the current game state on a move request, resolves walk / push / blocked over
// CALC and CHECK, then issues a single-cycle command strobe (en/sel/bm/mm) to
// game_retract. Also tracks a saturating step counter and a registered level-complete flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   game_state [133:0]  live state from game_retract ([133:128] player pos, [127:0] 64x2b map)
//   goal_mask  [63:0]   per-level goal cells
//   dir        [1:0]    00 up, 01 down, 10 left, 11 right
//   move_req, retract_req, restart_req   requests, sampled only when idle
//   real_retract        game_retract actually restored a state (sampled in SETTLE)
//   game_state_bm/mm    state before/after the committed move
//   game_state_en, sel  command strobe and code (0 reload, 1 commit, 2 retract)
//   busy, move_ok, pushed, level_done, step_cnt   status
module game_move #(
    parameter int unsigned STEP_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [133:0]      game_state,
    input  logic [63:0]       goal_mask,
    input  logic [1:0]        dir,
    input  logic              move_req,
    input  logic              retract_req,
    input  logic              restart_req,
    input  logic              real_retract,
    output logic [133:0]      game_state_bm,
    output logic [133:0]      game_state_mm,
    output logic              game_state_en,
    output logic [1:0]        sel,
    output logic              busy,
    output logic              move_ok,
    output logic              pushed,
    output logic              level_done,
    output logic [STEP_W-1:0] step_cnt
);

    typedef enum logic [2:0] {StIdle, StCalc, StCheck, StIssue, StSettle} state_e;

    localparam logic [1:0] CellFloor = 2'b00;
    localparam logic [1:0] CellBox   = 2'b10;
    localparam logic [1:0] SelLoad   = 2'd0;
    localparam logic [1:0] SelMove   = 2'd1;
    localparam logic [1:0] SelUndo   = 2'd2;
    localparam logic [STEP_W-1:0] StepMax = '1;

    state_e             state_q, state_d;
    logic [133:0]       s_q, s_d;
    logic [1:0]         d_q, d_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [5:0]         t1_q, t1_d, t2_q, t2_d;
    logic               edge1_q, edge1_d, edge2_q, edge2_d;
    logic [133:0]       mm_calc_q, mm_calc_d;
    logic               push_q, push_d;
    logic [133:0]       bm_q, bm_d, mm_q, mm_d;
    logic               en_q, en_d, move_ok_q, move_ok_d, pushed_q, pushed_d;
    logic [1:0]         sel_q, sel_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic [2:0]   row, col;
    logic [1:0]   c1, c2;
    logic [133:0] mm_tmp;
    logic         all_boxed;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        d_d       = d_q;
        cmd_d     = cmd_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        edge1_d   = edge1_q;
        edge2_d   = edge2_q;
        mm_calc_d = mm_calc_q;
        push_d    = push_q;
        bm_d      = bm_q;
        mm_d      = mm_q;
        en_d      = 1'b0;
        sel_d     = sel_q;
        move_ok_d = 1'b0;
        pushed_d  = 1'b0;
        step_d    = step_q;
        row       = s_q[133:131];
        col       = s_q[130:128];
        c1        = s_q[{t1_q, 1'b0} +: 2];
        c2        = s_q[{t2_q, 1'b0} +: 2];
        mm_tmp    = s_q;

        // Win flag tracks the live input, independent of the FSM.
        all_boxed = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (goal_mask[i] && game_state[2*i +: 2] != CellBox) all_boxed = 1'b0;
        end
        done_d = all_boxed && (|goal_mask);

        unique case (state_q)
            StIdle: begin
                if (restart_req) begin
                    cmd_d   = SelLoad;
                    state_d = StIssue;
                end else if (retract_req) begin
                    cmd_d   = SelUndo;
                    state_d = StIssue;
                end else if (move_req) begin
                    s_d     = game_state;
                    d_d     = dir;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // Wrapped targets are computed but always masked by the edge flags.
                unique case (d_q)
                    2'b00: begin
                        edge1_d = (row == 3'd0);
                        edge2_d = (row < 3'd2);
                        t1_d    = {row - 3'd1, col};
                        t2_d    = {row - 3'd2, col};
                    end
                    2'b01: begin
                        edge1_d = (row == 3'd7);
                        edge2_d = (row > 3'd5);
                        t1_d    = {row + 3'd1, col};
                        t2_d    = {row + 3'd2, col};
                    end
                    2'b10: begin
                        edge1_d = (col == 3'd0);
                        edge2_d = (col < 3'd2);
                        t1_d    = {row, col - 3'd1};
                        t2_d    = {row, col - 3'd2};
                    end
                    default: begin
                        edge1_d = (col == 3'd7);
                        edge2_d = (col > 3'd5);
                        t1_d    = {row, col + 3'd1};
                        t2_d    = {row, col + 3'd2};
                    end
                endcase
                state_d = StCheck;
            end
            StCheck: begin
                mm_tmp[133:128] = t1_q;
                state_d         = StIdle;
                if (!edge1_q && c1 == CellFloor) begin
                    mm_calc_d = mm_tmp;
                    push_d    = 1'b0;
                    cmd_d     = SelMove;
                    state_d   = StIssue;
                end else if (!edge1_q && c1 == CellBox && !edge2_q && c2 == CellFloor) begin
                    mm_tmp[{t1_q, 1'b0} +: 2] = CellFloor;
                    mm_tmp[{t2_q, 1'b0} +: 2] = CellBox;
                    mm_calc_d = mm_tmp;
                    push_d    = 1'b1;
                    cmd_d     = SelMove;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                // Outputs are registered, so the strobe is visible during SETTLE.
                en_d  = 1'b1;
                sel_d = cmd_q;
                if (cmd_q == SelMove) begin
                    bm_d      = s_q;
                    mm_d      = mm_calc_q;
                    move_ok_d = 1'b1;
                    pushed_d  = push_q;
                    if (step_q != StepMax) step_d = step_q + 1'b1;
                end else if (cmd_q == SelLoad) begin
                    step_d = '0;
                end
                state_d = StSettle;
            end
            default: begin
                if (cmd_q == SelUndo && real_retract && step_q != '0) step_d = step_q - 1'b1;
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s_q       <= '0;
            d_q       <= '0;
            cmd_q     <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            edge1_q   <= 1'b0;
            edge2_q   <= 1'b0;
            mm_calc_q <= '0;
            push_q    <= 1'b0;
            bm_q      <= '0;
            mm_q      <= '0;
            en_q      <= 1'b0;
            sel_q     <= '0;
            move_ok_q <= 1'b0;
            pushed_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            d_q       <= d_d;
            cmd_q     <= cmd_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            edge1_q   <= edge1_d;
            edge2_q   <= edge2_d;
            mm_calc_q <= mm_calc_d;
            push_q    <= push_d;
            bm_q      <= bm_d;
            mm_q      <= mm_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            move_ok_q <= move_ok_d;
            pushed_q  <= pushed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            step_q    <= step_d;
        end
    end

    assign game_state_bm = bm_q;
    assign game_state_mm = mm_q;
    assign game_state_en = en_q;
    assign sel           = sel_q;
    assign busy          = busy_q;
    assign move_ok       = move_ok_q;
    assign pushed        = pushed_q;
    assign level_done    = done_q;
    assign step_cnt      = step_q;

endmodule

// File: tb/tb_game_move.sv
// Directed bench for game_move: walk, push, blocked moves, undo, restart priority,
// request dropping, win flag and mid-operation reset.
module tb_game_move;

    logic         clk = 1'b0;
    logic         rst;
    logic [133:0] game_state;
    logic [63:0]  goal_mask;
    logic [1:0]   dir;
    logic         move_req, retract_req, restart_req, real_retract;
    logic [133:0] game_state_bm, game_state_mm;
    logic         game_state_en;
    logic [1:0]   sel;
    logic         busy, move_ok, pushed, level_done;
    logic [9:0]   step_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    game_move #(.STEP_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .game_state   (game_state),
        .goal_mask    (goal_mask),
        .dir          (dir),
        .move_req     (move_req),
        .retract_req  (retract_req),
        .restart_req  (restart_req),
        .real_retract (real_retract),
        .game_state_bm(game_state_bm),
        .game_state_mm(game_state_mm),
        .game_state_en(game_state_en),
        .sel          (sel),
        .busy         (busy),
        .move_ok      (move_ok),
        .pushed       (pushed),
        .level_done   (level_done),
        .step_cnt     (step_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then park on the falling edge for sampling/driving.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] mk(input logic [5:0] pos);
        return {pos, 128'b0};
    endfunction

    function automatic logic [133:0] setc(input logic [133:0] s, input int i,
                                          input logic [1:0] c);
        logic [133:0] r;
        r = s;
        r[2*i +: 2] = c;
        return r;
    endfunction

    // Move request that must be rejected: no strobe, busy drops, step count untouched.
    task automatic blocked(input string tag, input logic [133:0] st, input logic [1:0] d,
                           input logic [9:0] step_exp);
        game_state = st;
        dir        = d;
        move_req   = 1'b1;
        cyc(1);
        move_req = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        cyc(2);
        chk({tag, "_en"}, game_state_en, 0);
        chk({tag, "_idle"}, busy, 0);
        cyc(1);
        chk({tag, "_en_late"}, game_state_en, 0);
        chk({tag, "_step"}, step_cnt, step_exp);
    endtask

    logic [133:0] st, exp_mm;

    initial begin
        rst = 1'b1;
        game_state = '0;
        goal_mask = '0;
        dir = '0;
        move_req = 0; retract_req = 0; restart_req = 0; real_retract = 0;
        cyc(2);
        rst = 1'b0;
        chk("rst_en", game_state_en, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bm", game_state_bm, 0);
        chk("rst_mm", game_state_mm, 0);
        chk("rst_step", step_cnt, 0);
        chk("rst_done", level_done, 0);

        // Walk right from 9 to 10.
        st = mk(6'd9);
        game_state = st; dir = 2'b11; move_req = 1'b1;
        cyc(1);
        move_req = 1'b0;
        chk("walk_busy", busy, 1);
        chk("walk_en_early", game_state_en, 0);
        cyc(2);
        chk("walk_en_n2", game_state_en, 0);
        cyc(1);
        chk("walk_en", game_state_en, 1);
        chk("walk_sel", sel, 1);
        chk("walk_mm", game_state_mm, mk(6'd10));
        chk("walk_bm", game_state_bm, st);
        chk("walk_step", step_cnt, 1);
        chk("walk_ok", move_ok, 1);
        chk("walk_pushed", pushed, 0);
        game_state = mk(6'd10);
        cyc(1);
        chk("walk_en_off", game_state_en, 0);
        chk("walk_ok_off", move_ok, 0);
        chk("walk_idle", busy, 0);
        chk("walk_bm_hold", game_state_bm, st);

        // Push a box from 10 onto goal 11.
        goal_mask = 64'd1 << 11;
        st = setc(mk(6'd9), 10, 2'b10);
        game_state = st; dir = 2'b11; move_req = 1'b1;
        cyc(1);
        move_req = 1'b0;
        chk("push_done_pre", level_done, 0);
        cyc(3);
        exp_mm = setc(mk(6'd10), 11, 2'b10);
        chk("push_en", game_state_en, 1);
        chk("push_mm", game_state_mm, exp_mm);
        chk("push_bm", game_state_bm, st);
        chk("push_pushed", pushed, 1);
        chk("push_step", step_cnt, 2);
        game_state = exp_mm;
        cyc(1);
        chk("push_done", level_done, 1);
        chk("push_pushed_off", pushed, 0);

        // Blocked moves.
        blocked("blk_wall", setc(mk(6'd9), 10, 2'b01), 2'b11, 10'd2);
        blocked("blk_rsvd", setc(mk(6'd9), 10, 2'b11), 2'b11, 10'd2);
        blocked("blk_2box", setc(setc(mk(6'd9), 10, 2'b10), 11, 2'b10), 2'b11, 10'd2);
        blocked("blk_redge", mk(6'd7), 2'b11, 10'd2);
        blocked("blk_tedge", mk(6'd0), 2'b00, 10'd2);
        blocked("blk_push_edge", setc(mk(6'd6), 7, 2'b10), 2'b11, 10'd2);
        blocked("blk_ledge", mk(6'd8), 2'b10, 10'd2);

        // Walk down from row 0 to row 1.
        game_state = mk(6'd3); dir = 2'b01; move_req = 1'b1;
        cyc(1);
        move_req = 1'b0;
        cyc(3);
        chk("down_mm", game_state_mm, mk(6'd11));
        chk("down_step", step_cnt, 3);
        cyc(1);

        // Undo with and without a real restore.
        retract_req = 1'b1;
        cyc(1);
        retract_req = 1'b0;
        chk("undo_busy", busy, 1);
        chk("undo_en_early", game_state_en, 0);
        cyc(1);
        chk("undo_en", game_state_en, 1);
        chk("undo_sel", sel, 2);
        chk("undo_ok", move_ok, 0);
        real_retract = 1'b1;
        cyc(1);
        real_retract = 1'b0;
        chk("undo_step", step_cnt, 2);
        chk("undo_idle", busy, 0);
        retract_req = 1'b1;
        cyc(1);
        retract_req = 1'b0;
        cyc(2);
        chk("undo_noop_step", step_cnt, 2);

        // All three requests together: restart wins.
        restart_req = 1'b1; retract_req = 1'b1; move_req = 1'b1;
        game_state = mk(6'd9); dir = 2'b11;
        cyc(1);
        restart_req = 1'b0; retract_req = 1'b0; move_req = 1'b0;
        cyc(1);
        chk("prio_en", game_state_en, 1);
        chk("prio_sel", sel, 0);
        chk("prio_step", step_cnt, 0);
        cyc(1);
        chk("prio_idle", busy, 0);
        cyc(2);
        chk("prio_no_second", game_state_en, 0);

        // Undo at zero stays at zero.
        retract_req = 1'b1;
        cyc(1);
        retract_req = 1'b0;
        cyc(1);
        real_retract = 1'b1;
        cyc(1);
        real_retract = 1'b0;
        chk("undo_sat0", step_cnt, 0);

        // move_req held while busy is dropped.
        game_state = mk(6'd9); dir = 2'b11; move_req = 1'b1;
        cyc(3);
        move_req = 1'b0;
        cyc(1);
        chk("drop_en1", game_state_en, 1);
        chk("drop_step", step_cnt, 1);
        cyc(1);
        chk("drop_off", game_state_en, 0);
        cyc(1);
        chk("drop_idle", busy, 0);
        cyc(2);
        chk("drop_no_second", game_state_en, 0);
        chk("drop_step_hold", step_cnt, 1);

        // Reset while in CHECK aborts cleanly.
        move_req = 1'b1;
        cyc(1);
        move_req = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rstchk_en", game_state_en, 0);
        chk("rstchk_busy", busy, 0);
        chk("rstchk_step", step_cnt, 0);
        chk("rstchk_bm", game_state_bm, 0);
        chk("rstchk_mm", game_state_mm, 0);
        chk("rstchk_sel", sel, 0);
        cyc(3);
        chk("rstchk_no_en", game_state_en, 0);

        // Win flag boundaries.
        goal_mask  = '1;
        game_state = {6'd0, {64{2'b10}}};
        cyc(1);
        chk("win_all", level_done, 1);
        goal_mask = '0;
        cyc(1);
        chk("win_nogoal", level_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
